// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter in front of the FPro MMIO bus.
// Each grant becomes one registered bus cycle followed by a one-cycle ack to the owner.
module mmio_bus_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_rd,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_rd,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              lock_vld_q, lock_vld_d;
  logic              lock_own_q, lock_own_d;
  logic              gnt_q, gnt_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic              cmd_lock_q, cmd_lock_d;
  logic              mmio_cs_q, mmio_cs_d;
  logic              mmio_wr_q, mmio_wr_d;
  logic              mmio_rd_q, mmio_rd_d;
  logic [ADDR_W-1:0] mmio_addr_q, mmio_addr_d;
  logic [DATA_W-1:0] mmio_wr_data_q, mmio_wr_data_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rd_data_q, m0_rd_data_d, m1_rd_data_q, m1_rd_data_d;

  logic              elig0, elig1, sel, sel_wr, sel_rd;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    lock_vld_d     = lock_vld_q;
    lock_own_d     = lock_own_q;
    gnt_d          = gnt_q;
    cmd_rd_d       = cmd_rd_q;
    cmd_lock_d     = cmd_lock_q;
    mmio_cs_d      = 1'b0;
    mmio_wr_d      = 1'b0;
    mmio_rd_d      = 1'b0;
    mmio_addr_d    = '0;
    mmio_wr_data_d = '0;
    m0_ack_d       = 1'b0;
    m1_ack_d       = 1'b0;
    m0_err_d       = 1'b0;
    m1_err_d       = 1'b0;
    m0_rd_data_d   = m0_rd_data_q;
    m1_rd_data_d   = m1_rd_data_q;

    // A held lock restricts eligibility to its owner only.
    elig0  = m0_req && (!lock_vld_q || !lock_own_q);
    elig1  = m1_req && (!lock_vld_q ||  lock_own_q);
    sel    = (elig0 && elig1) ? ~last_q : elig1;
    sel_wr = sel ? m1_wr : m0_wr;
    sel_rd = sel ? m1_rd : m0_rd;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          gnt_d      = sel;
          cmd_rd_d   = sel_rd;
          cmd_lock_d = sel ? m1_lock : m0_lock;
          if (sel_wr ^ sel_rd) begin
            mmio_cs_d      = 1'b1;
            mmio_wr_d      = sel_wr;
            mmio_rd_d      = sel_rd;
            mmio_addr_d    = sel ? m1_addr : m0_addr;
            mmio_wr_data_d = sel ? m1_wr_data : m0_wr_data;
            state_d        = ISSUE;
          end else begin
            // Illegal command never touches the bus; ack straight away with err.
            if (sel) begin
              m1_ack_d     = 1'b1;
              m1_err_d     = 1'b1;
              m1_rd_data_d = '0;
            end else begin
              m0_ack_d     = 1'b1;
              m0_err_d     = 1'b1;
              m0_rd_data_d = '0;
            end
            state_d = ACK;
          end
        end
      end
      ISSUE: begin
        if (gnt_q) begin
          m1_ack_d     = 1'b1;
          m1_rd_data_d = cmd_rd_q ? mmio_rd_data : '0;
        end else begin
          m0_ack_d     = 1'b1;
          m0_rd_data_d = cmd_rd_q ? mmio_rd_data : '0;
        end
        state_d = ACK;
      end
      ACK: begin
        last_d     = gnt_q;
        lock_vld_d = cmd_lock_q;
        lock_own_d = gnt_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      lock_vld_q     <= 1'b0;
      lock_own_q     <= 1'b0;
      gnt_q          <= 1'b0;
      cmd_rd_q       <= 1'b0;
      cmd_lock_q     <= 1'b0;
      mmio_cs_q      <= 1'b0;
      mmio_wr_q      <= 1'b0;
      mmio_rd_q      <= 1'b0;
      mmio_addr_q    <= '0;
      mmio_wr_data_q <= '0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m0_err_q       <= 1'b0;
      m1_err_q       <= 1'b0;
      m0_rd_data_q   <= '0;
      m1_rd_data_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      lock_vld_q     <= lock_vld_d;
      lock_own_q     <= lock_own_d;
      gnt_q          <= gnt_d;
      cmd_rd_q       <= cmd_rd_d;
      cmd_lock_q     <= cmd_lock_d;
      mmio_cs_q      <= mmio_cs_d;
      mmio_wr_q      <= mmio_wr_d;
      mmio_rd_q      <= mmio_rd_d;
      mmio_addr_q    <= mmio_addr_d;
      mmio_wr_data_q <= mmio_wr_data_d;
      m0_ack_q       <= m0_ack_d;
      m1_ack_q       <= m1_ack_d;
      m0_err_q       <= m0_err_d;
      m1_err_q       <= m1_err_d;
      m0_rd_data_q   <= m0_rd_data_d;
      m1_rd_data_q   <= m1_rd_data_d;
    end
  end

  assign mmio_cs      = mmio_cs_q;
  assign mmio_wr      = mmio_wr_q;
  assign mmio_rd      = mmio_rd_q;
  assign mmio_addr    = mmio_addr_q;
  assign mmio_wr_data = mmio_wr_data_q;
  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign m0_err       = m0_err_q;
  assign m1_err       = m1_err_q;
  assign m0_rd_data   = m0_rd_data_q;
  assign m1_rd_data   = m1_rd_data_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed testbench for mmio_bus_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mmio_bus_arbiter;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              m0_req = 0, m0_wr = 0, m0_rd = 0, m0_lock = 0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wr_data = '0;
  logic              m0_ack, m0_err;
  logic [DATA_W-1:0] m0_rd_data;
  logic              m1_req = 0, m1_wr = 0, m1_rd = 0, m1_lock = 0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wr_data = '0;
  logic              m1_ack, m1_err;
  logic [DATA_W-1:0] m1_rd_data;
  logic              mmio_cs, mmio_wr, mmio_rd;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wr_data;
  logic [DATA_W-1:0] mmio_rd_data;
  logic [DATA_W-1:0] stub_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stub MMIO controller: combinational read data while a read is on the bus.
  assign mmio_rd_data = (mmio_cs && mmio_rd) ? stub_val : '0;

  mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd_data(m1_rd_data),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  int m0_cnt, m1_cnt, cs_seen, got;
  int t, ph, mst;

  initial begin
    // Reset state
    #2;
    chk("rst_bus", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, 64'd0);
    chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 64'd0);
    chk("rst_rdata", {m0_rd_data, m1_rd_data}, 64'd0);
    cyc(); cyc();
    reset = 1'b1;

    // 1: M0 write 0xA5 to 0x0C0
    cyc();
    m0_req = 1; m0_wr = 1; m0_rd = 0; m0_addr = 21'h0C0; m0_wr_data = 32'h0000_00A5;
    cyc();
    chk("t1_bus", {mmio_cs, mmio_wr, mmio_rd}, 64'b110);
    chk("t1_addr", mmio_addr, 64'h0C0);
    chk("t1_wdata", mmio_wr_data, 64'hA5);
    chk("t1_early_ack", m0_ack, 64'd0);
    cyc();
    chk("t1_ack", {m0_ack, m0_err, m1_ack}, 64'b100);
    chk("t1_cs_off", mmio_cs, 64'd0);
    m0_req = 0; m0_wr = 0;
    cyc();
    chk("t1_ack_pulse", {m0_ack, m1_ack}, 64'd0);

    // 2: M1 read 0x100, stub returns DEADBEEF
    stub_val = 32'hDEAD_BEEF;
    m1_req = 1; m1_rd = 1; m1_addr = 21'h100;
    cyc();
    chk("t2_bus", {mmio_cs, mmio_wr, mmio_rd}, 64'b101);
    chk("t2_addr", mmio_addr, 64'h100);
    cyc();
    chk("t2_ack", {m1_ack, m1_err, m0_ack, mmio_rd}, 64'b1000);
    chk("t2_rdata", m1_rd_data, 64'hDEAD_BEEF);
    chk("t2_m0_untouched", m0_rd_data, 64'd0);
    m1_req = 0; m1_rd = 0;
    cyc();
    chk("t2_rdata_held", m1_rd_data, 64'hDEAD_BEEF);

    // 3: both request continuously from reset
    reset = 0;
    cyc();
    reset = 1;
    m0_req = 1; m0_wr = 1; m0_addr = 21'h010; m0_wr_data = 32'h1;
    m1_req = 1; m1_wr = 1; m1_addr = 21'h020; m1_wr_data = 32'h2;
    m0_cnt = 0; m1_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      t = (k - 1) / 3; ph = (k - 1) % 3; mst = t % 2;
      if (m0_ack) m0_cnt++;
      if (m1_ack) m1_cnt++;
      if (ph == 0) begin
        chk($sformatf("t3_cs_%0d", k), mmio_cs, 64'd1);
        chk($sformatf("t3_addr_%0d", k), mmio_addr, (mst == 0) ? 64'h010 : 64'h020);
      end else if (ph == 1) begin
        chk($sformatf("t3_ack_%0d", k), {m0_ack, m1_ack}, (mst == 0) ? 64'b10 : 64'b01);
      end else begin
        chk($sformatf("t3_idle_%0d", k), {mmio_cs, m0_ack, m1_ack}, 64'd0);
      end
    end
    m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
    chk("t3_m0_count", m0_cnt, 64'd2);
    chk("t3_m1_count", m1_cnt, 64'd2);
    cyc(); cyc();

    // 4: M1 locked read, then M1 unlock write competes with M0 read
    stub_val = 32'h1234_5678;
    m1_req = 1; m1_rd = 1; m1_lock = 1; m1_addr = 21'h030;
    cyc(); cyc();
    chk("t4_lock_ack", m1_ack, 64'd1);
    chk("t4_lock_rdata", m1_rd_data, 64'h1234_5678);
    m1_rd = 0; m1_wr = 1; m1_lock = 0; m1_addr = 21'h034; m1_wr_data = 32'h55;
    m0_req = 1; m0_rd = 1; m0_addr = 21'h040;
    cyc();
    chk("t4_idle", mmio_cs, 64'd0);
    cyc();
    chk("t4_m1_first", {mmio_cs, mmio_wr, mmio_addr}, {41'd0, 1'b1, 1'b1, 21'h034});
    stub_val = 32'hCAFE_0001;
    cyc();
    chk("t4_m1_ack", {m1_ack, m0_ack}, 64'b10);
    chk("t4_m1_wr_rdata", m1_rd_data, 64'd0);
    m1_req = 0; m1_wr = 0;
    cyc(); cyc();
    chk("t4_m0_bus", {mmio_cs, mmio_rd, mmio_addr}, {42'd0, 1'b1, 1'b1, 21'h040});
    cyc();
    chk("t4_m0_ack", {m0_ack, m1_ack}, 64'b10);
    chk("t4_m0_rdata", m0_rd_data, 64'hCAFE_0001);
    m0_req = 0; m0_rd = 0;
    cyc(); cyc();

    // 5: illegal command rd=wr=1
    m0_req = 1; m0_rd = 1; m0_wr = 1; m0_addr = 21'h050;
    cs_seen = 0; got = 0;
    for (int i = 0; i < 4 && got == 0; i++) begin
      cyc();
      if (mmio_cs) cs_seen++;
      if (m0_ack) begin
        got = 1;
        chk("t5_err", m0_err, 64'd1);
        chk("t5_rdata", m0_rd_data, 64'd0);
      end
    end
    m0_req = 0; m0_rd = 0; m0_wr = 0;
    chk("t5_got_ack", got, 64'd1);
    chk("t5_no_cs", cs_seen, 64'd0);
    cyc(); cyc();

    // 6: reset during ISSUE, then fresh request
    m0_req = 1; m0_wr = 1; m0_addr = 21'h060; m0_wr_data = 32'h77;
    cyc();
    chk("t6_issue", mmio_cs, 64'd1);
    reset = 0;
    #1;
    chk("t6_rst_bus", {mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}, 64'd0);
    chk("t6_rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 64'd0);
    m0_req = 0; m0_wr = 0;
    cyc();
    reset = 1;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (m0_ack || m1_ack) got++;
    end
    chk("t6_no_ack", got, 64'd0);
    m0_req = 1; m0_wr = 1; m0_addr = 21'h070; m0_wr_data = 32'h99;
    cyc();
    chk("t6_fresh_bus", {mmio_cs, mmio_wr, mmio_addr}, {41'd0, 1'b1, 1'b1, 21'h070});
    cyc();
    chk("t6_fresh_ack", {m0_ack, m0_err, m1_ack}, 64'b100);
    m0_req = 0; m0_wr = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
